aes256_inv_cipher_iter: RTL and testbench

Iterative AES-256 decryption engine. It is the inverse-direction counterpart of the team's forward round datapath. The block applies one full inverse round per clock to a latched 128-bit state. Round keys come from an external round-key store addressed by rk_idx. Ciphertext is accepted and plaintext returned over valid/ready handshakes, one block in flight at a time.

---
 rtl/aes256_inv_cipher_iter.sv | 168 ++++++++++++++++
 tb/tb_aes256_inv_cipher_iter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys read from an external store via rk_idx.
// Build macro AES_INV_BACK_TO_BACK_EN lets a new ciphertext enter in the same cycle the plaintext is released.

module aes256_inv_cipher_iter #(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [3:0] NR_IDX  = 4'(NR);
  localparam logic [3:0] NR_LAST = 4'(NR - 1);

  state_t       state, state_nxt;
  logic [127:0] state_reg;
  logic [3:0]   rcnt;
  logic [127:0] shifted, subbed, added, mixed;

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multipliers 9/b/d/e are built from the x2/x4/x8 xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [3:0][7:0] a, m9, mb, md, me;
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Byte (col c, row r) sits at index 4c+r; row r rotates right by r.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = state_reg[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .a (shifted[8*i +: 8]),
      .y (subbed[8*i +: 8])
    );
  end

  assign added = subbed ^ rk;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(added[127-32*c -: 32]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    rk_idx    = NR_IDX;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ROUND;
      end
      ROUND: begin
        rk_idx = rcnt;
        if (rcnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
`ifdef AES_INV_BACK_TO_BACK_EN
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? ROUND : IDLE;
`else
        if (out_ready) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A load always restarts the round counter, which also covers the back-to-back path out of DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      rcnt      <= '0;
      pt        <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        state_reg <= ct ^ rk;
        rcnt      <= NR_LAST;
      end else if (state == ROUND && rcnt != 4'd0) begin
        state_reg <= mixed;
        rcnt      <= rcnt - 4'd1;
      end
      if (state == ROUND && rcnt == 4'd0) begin
        pt        <= added;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc;
    logic [7:0] t;
    acc = 8'h00;
    t   = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] b, p2, p4, p8, p16, p32, p64, p128;

  // Undo the affine map, then invert in GF(2^8) as b^254 so zero maps to zero.
  always_comb begin
    b    = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    p2   = gf_mul(b, b);
    p4   = gf_mul(p2, p2);
    p8   = gf_mul(p4, p4);
    p16  = gf_mul(p8, p8);
    p32  = gf_mul(p16, p16);
    p64  = gf_mul(p32, p32);
    p128 = gf_mul(p64, p64);
    y    = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                  gf_mul(gf_mul(p32, p64), p128));
  end

endmodule

// File: tb/tb_aes256_inv_cipher_iter.sv
// Self-checking bench for aes256_inv_cipher_iter: FIPS-197 vectors plus random blocks encrypted by a forward AES model.
// Honours AES_INV_BACK_TO_BACK_EN for the expected accept spacing and DONE-state in_ready.

module tb_aes256_inv_cipher_iter;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_REF = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_INV_BACK_TO_BACK_EN
  localparam int   EXP_SPACING    = 15;
  localparam logic EXP_DONE_READY = 1'b1;
`else
  localparam int   EXP_SPACING    = 16;
  localparam logic EXP_DONE_READY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [127:0] ct = '0, rk, pt;
  logic [3:0] rk_idx;
  logic in_valid10 = 1'b0, out_ready10 = 1'b1, in_ready10, out_valid10;
  logic [127:0] ct10 = '0, rk10, pt10;
  logic [3:0] rk_idx10;

  logic [127:0] rk_mem   [0:15];
  logic [127:0] rk_mem10 [0:15];
  logic [7:0]   sbox_tab [0:255];
  logic [31:0]  w        [0:63];
  logic [127:0] ks       [0:15];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rk   = rk_mem[rk_idx];
  assign rk10 = rk_mem10[rk_idx10];

  aes256_inv_cipher_iter #(.NR(14)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ct(ct),
    .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid), .out_ready(out_ready), .pt(pt)
  );

  aes256_inv_cipher_iter #(.NR(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10), .ct(ct10),
    .rk_idx(rk_idx10), .rk(rk10), .out_valid(out_valid10), .out_ready(out_ready10), .pt(pt10)
  );

  // ---------------- forward AES reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc, t;
    acc = 8'h00;
    t = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  task automatic init_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    int nr;
    logic [31:0] t;
    logic [7:0] rc;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         ks[r] = '0;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] p, input int nr);
    logic [7:0] s [0:15];
    logic [7:0] t [0:15];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] v;
    v = p ^ ks[0];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox_tab[v[127-8*b -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) v[127-8*b -: 8] = t[b];
      v = v ^ ks[rnd];
    end
    return v;
  endfunction

  task automatic load_rk();
    for (int i = 0; i < 16; i++) rk_mem[i] = ks[i];
  endtask

  task automatic load_rk10();
    for (int i = 0; i < 16; i++) rk_mem10[i] = ks[i];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [127:0] c, output bit ok);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    ok = (in_ready === 1'b1);
    in_valid = 1'b1;
    ct = c;
    step();
    in_valid = 1'b0;
    ct = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (pt !== 128'h0) begin errors++; $display("[TB] FAIL reset_pt: got %h want 0", pt); end
    checks++; if (rk_idx !== 4'd14) begin errors++; $display("[TB] FAIL reset_rk_idx: got %0d want 14", rk_idx); end
    checks++; if (rk_idx10 !== 4'd10) begin errors++; $display("[TB] FAIL reset_rk_idx_nr10: got %0d want 10", rk_idx10); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_fips_c3();
    bit ok;
    int n;
    expand_key(C3_KEY, 8);
    load_rk();
    out_ready = 1'b1;
    checks++; if (rk_idx !== 4'd14) begin errors++; $display("[TB] FAIL c3_idle_rk_idx: got %0d want 14", rk_idx); end
    start_block(C3_CT, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL c3_accept: in_ready never rose"); end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      checks++;
      if (rk_idx !== 4'(13 - n)) begin errors++; $display("[TB] FAIL c3_rk_idx_seq: cycle %0d got %0d want %0d", n, rk_idx, 13 - n); end
      step();
      n++;
    end
    checks++; if (n != 14) begin errors++; $display("[TB] FAIL c3_latency: got %0d want 14", n); end
    checks++; if (pt !== PT_REF) begin errors++; $display("[TB] FAIL c3_pt: got %h want %h", pt, PT_REF); end
    checks++; if (in_ready !== EXP_DONE_READY) begin errors++; $display("[TB] FAIL c3_done_in_ready: got %b want %b", in_ready, EXP_DONE_READY); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL c3_release: out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL c3_idle_again: in_ready got %b want 1", in_ready); end
    checks++; if (pt !== PT_REF) begin errors++; $display("[TB] FAIL c3_pt_hold: got %h want %h", pt, PT_REF); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    expand_key(C3_KEY, 8);
    load_rk();
    out_ready = 1'b0;
    start_block(C3_CT, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_accept: in_ready never rose"); end
    wait_out(n);
    checks++; if (n != 14) begin errors++; $display("[TB] FAIL bp_latency: got %0d want 14", n); end
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      ct = {$urandom, $urandom, $urandom, $urandom};
      checks++; if (out_valid !== 1'b1 || pt !== PT_REF) begin errors++; $display("[TB] FAIL bp_hold: cycle %0d valid %b pt %h want 1 %h", i, out_valid, pt, PT_REF); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: cycle %0d got %b want 0", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b1 || pt !== PT_REF) begin errors++; $display("[TB] FAIL bp_pre_release: valid %b pt %h", out_valid, pt); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after: got %b want 1", in_ready); end
    repeat (3) step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_latch: in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    expand_key(C3_KEY, 8);
    load_rk();
    out_ready = 1'b1;
    start_block(C3_CT, ok);
    repeat (7) step();
    checks++; if (in_ready !== 1'b0 || rk_idx !== 4'd6) begin errors++; $display("[TB] FAIL mid_round7: in_ready %b rk_idx %0d want 0 6", in_ready, rk_idx); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_out_valid: got %b want 0", out_valid); end
    checks++; if (pt !== 128'h0) begin errors++; $display("[TB] FAIL mid_reset_pt: got %h want 0", pt); end
    checks++; if (rk_idx !== 4'd14) begin errors++; $display("[TB] FAIL mid_reset_rk_idx: got %0d want 14", rk_idx); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    start_block(C3_CT, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_accept: in_ready never rose"); end
    wait_out(n);
    checks++; if (n != 14) begin errors++; $display("[TB] FAIL mid_latency: got %0d want 14", n); end
    checks++; if (pt !== PT_REF) begin errors++; $display("[TB] FAIL mid_pt: got %h want %h", pt, PT_REF); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [255:0] key;
    logic [127:0] pa, pb, ca, cb, g0, g1;
    logic [127:0] got [$];
    int nacc, t, acc0, acc1;
    bit accepted;
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    expand_key(key, 8);
    load_rk();
    pa = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    ca = encrypt(pa, 14);
    cb = encrypt(pb, 14);
    out_ready = 1'b1;
    in_valid = 1'b1;
    ct = ca;
    nacc = 0; t = 0; acc0 = 0; acc1 = 0;
    while ((nacc < 2 || got.size() < 2) && t < 200) begin
      if (out_valid === 1'b1) got.push_back(pt);
      accepted = (in_valid === 1'b1 && in_ready === 1'b1);
      if (accepted) begin
        if (nacc == 0) acc0 = t; else acc1 = t;
        nacc++;
      end
      step();
      t++;
      if (accepted && nacc == 1) ct = cb;
      if (accepted && nacc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    g0 = (got.size() > 0) ? got[0] : '0;
    g1 = (got.size() > 1) ? got[1] : '0;
    checks++; if (nacc != 2 || got.size() != 2) begin errors++; $display("[TB] FAIL b2b_timeout: accepted %0d outputs %0d want 2 2", nacc, got.size()); end
    checks++; if (acc1 - acc0 != EXP_SPACING) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", acc1 - acc0, EXP_SPACING); end
    checks++; if (g0 !== pa) begin errors++; $display("[TB] FAIL b2b_pt0: got %h want %h", g0, pa); end
    checks++; if (g1 !== pb) begin errors++; $display("[TB] FAIL b2b_pt1: got %h want %h", g1, pb); end
    repeat (2) step();
  endtask

  task automatic test_random();
    logic [255:0] key;
    logic [127:0] p, c;
    bit ok;
    int n;
    for (int it = 0; it < 1000; it++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand_key(key, 8);
      load_rk();
      p = {$urandom, $urandom, $urandom, $urandom};
      c = encrypt(p, 14);
      out_ready = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      start_block(c, ok);
      wait_out(n);
      if (out_ready == 1'b0) begin
        repeat ($urandom_range(1, 3)) step();
        out_ready = 1'b1;
      end
      checks++;
      if (!ok || out_valid !== 1'b1 || pt !== p) begin
        errors++;
        $display("[TB] FAIL random_pt: block %0d valid %b got %h want %h", it, out_valid, pt, p);
      end
      step();
    end
  endtask

  task automatic test_nr10();
    logic [127:0] key, p, c;
    int n;
    for (int it = 0; it < 21; it++) begin
      if (it == 0) begin
        key = C1_KEY; p = PT_REF; c = C1_CT;
        expand_key({key, 128'h0}, 4);
      end else begin
        key = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        expand_key({key, 128'h0}, 4);
        c = encrypt(p, 10);
      end
      load_rk10();
      out_ready10 = 1'b1;
      checks++; if (in_ready10 !== 1'b1 || rk_idx10 !== 4'd10) begin errors++; $display("[TB] FAIL nr10_idle: in_ready %b rk_idx %0d want 1 10", in_ready10, rk_idx10); end
      in_valid10 = 1'b1;
      ct10 = c;
      step();
      in_valid10 = 1'b0;
      ct10 = {$urandom, $urandom, $urandom, $urandom};
      n = 0;
      while (out_valid10 !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      checks++; if (n != 10) begin errors++; $display("[TB] FAIL nr10_latency: block %0d got %0d want 10", it, n); end
      checks++; if (pt10 !== p) begin errors++; $display("[TB] FAIL nr10_pt: block %0d got %h want %h", it, pt10, p); end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rk_mem[i] = '0;
      rk_mem10[i] = '0;
    end
    init_tables();
    test_reset();
    test_fips_c3();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_nr10();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
